// File: rtl/seq_bin2bcd_ctrl.sv
// Purpose: sequential binary-to-BCD converter (shift-and-add-3), one correct-and-shift step per clock.
// Latency: start accepted at edge k -> done pulses for the cycle after edge k+WIDTH; bcd_out updates on that edge.
// Backpressure: none; start is honoured only in IDLE, requests during SHIFT or DONE are dropped, not queued.
module seq_bin2bcd_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] bin_q,   bin_d;
    logic [BW-1:0]    work_q,  work_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [BW-1:0]    bcd_q,   bcd_d;
    logic [BW-1:0]    corr;

    // Add-3 correction cell: any digit that would reach 10+ after doubling is pre-biased by 3.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // Correct every digit of the working BCD value independently (no inter-digit carry).
    always_comb begin
        corr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            corr[4*i +: 4] = add3(work_q[4*i +: 4]);
        end
    end

    // Next-state and datapath: latch operand in IDLE, step once per clock in SHIFT, publish on the last step.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Corrected digits and operand shift left as one register; operand MSB feeds the ones digit.
                {work_d, bin_d} = {corr[BW-2:0], bin_q, 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d   = {corr[BW-2:0], bin_q[WIDTH-1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_seq_bin2bcd_ctrl.sv
module tb_seq_bin2bcd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seq_bin2bcd_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Pulse start for one cycle with operand v, then wait (bounded) for done.
    // lat = edges from acceptance to the done cycle, nb = cycles busy was seen high.
    task automatic conv(input logic [7:0] v, output int lat, output int nb);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        nb  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) break;
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, nb, npulse, t_prev, stable;
        logic [11:0] prev;
        logic [7:0]  seq_v [3];
        logic [11:0] seq_e [3];

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = 8'd0;

        // Reset state
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd",  32'(bcd_out), 32'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero operand still takes the full step count
        conv(8'd0, lat, nb);
        chk("zero_lat",  32'(lat), 32'd8);
        chk("zero_busy", 32'(nb),  32'd8);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_bcd",  32'(bcd_out), 32'h000);

        // Max operand; busy low during done, done lasts exactly one cycle
        conv(8'd255, lat, nb);
        chk("max_lat",       32'(lat), 32'd8);
        chk("max_bcd",       32'(bcd_out), 32'h255);
        chk("max_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("max_done_low",  32'(done), 32'd0);

        // Operand change and start re-pulse during busy are ignored
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd99;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd7;
        @(negedge clk);
        start  = 1'b0;
        npulse = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) begin
                npulse++;
                chk("busy99_bcd", 32'(bcd_out), 32'h099);
            end
        end
        chk("busy99_pulses", 32'(npulse), 32'd1);
        chk("busy99_hold",   32'(bcd_out), 32'h099);

        // start held high: back-to-back acceptances, operand stepped after each
        seq_v[0] = 8'd10;   seq_e[0] = 12'h010;
        seq_v[1] = 8'd59;   seq_e[1] = 12'h059;
        seq_v[2] = 8'd128;  seq_e[2] = 12'h128;
        prev   = 12'h099;
        t_prev = 0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = seq_v[0];
        @(posedge clk);
        #1 bin_in = seq_v[1];
        for (int n = 0; n < 3; n++) begin
            stable = 1;
            lat = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done) break;
                if (bcd_out !== prev) stable = 0;
                lat++;
            end
            chk($sformatf("held_stable%0d", n), 32'(stable), 32'd1);
            chk($sformatf("held_done%0d", n),   32'(done), 32'd1);
            chk($sformatf("held_bcd%0d", n),    32'(bcd_out), 32'(seq_e[n]));
            if (n > 0) chk($sformatf("held_gap%0d", n), 32'(cyc - t_prev), 32'd10);
            t_prev = cyc;
            prev   = seq_e[n];
            if (n < 2) begin
                @(posedge clk);
                @(posedge clk);
                #1 bin_in = (n == 0) ? seq_v[2] : 8'd0;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_idle_bcd", 32'(bcd_out), 32'h128);

        // Asynchronous reset mid-conversion aborts with no done pulse
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd200;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 chk("abort_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd",  32'(bcd_out), 32'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        chk("abort_no_done", 32'(npulse), 32'd0);
        conv(8'd37, lat, nb);
        chk("post_abort_lat", 32'(lat), 32'd8);
        chk("post_abort_bcd", 32'(bcd_out), 32'h037);

        // Full operand sweep against the decimal model
        for (int v = 0; v < 256; v++) begin
            conv(8'(v), lat, nb);
            chk($sformatf("sweep_lat_%0d", v), 32'(lat), 32'd8);
            chk($sformatf("sweep_bcd_%0d", v), 32'(bcd_out), 32'(model(v)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
